// File: rtl/prio_enc_pkg.sv
// Shared helpers for the priority event encoder: index-width derivation and a
// wrapping find-first-set used by the selection logic.
package prio_enc_pkg;

    // Widest request vector the wrapping search supports.
    localparam int MAX_N = 64;
    localparam int MAX_W = 6;

    // Index width for n sources; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Index of the first set bit of vec[n-1:0] at or after start, wrapping
    // modulo n. Returns 0 when no bit is set. start must be below n.
    function automatic int unsigned ffs_from(input logic [MAX_N-1:0] vec,
                                             input int unsigned      start,
                                             input int unsigned      n);
        int unsigned pos;
        logic        found;
        ffs_from = 0;
        found    = 1'b0;
        pos      = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (!found && (i < n)) begin
                pos = start + i;
                if (pos >= n) begin
                    pos = pos - n;
                end
                if (vec[pos[MAX_W-1:0]]) begin
                    ffs_from = pos;
                    found    = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/prio_event_encoder_pick.sv
// Combinational masked find-first-set: lowest set bit of vec at or above
// start, wrapping modulo N.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_N-1:0] vec_ext;

    // Zero-extend the request vector to the search width used by the helper.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_N; gi++) begin : g_ext
            if (gi < N) begin : g_src
                assign vec_ext[gi] = vec[gi];
            end else begin : g_pad
                assign vec_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Select the first pending source from the start point; index is 0 when idle.
    always_comb begin
        any = |vec;
        idx = '0;
        if (any) begin
            idx = IDX_W'(ffs_from(vec_ext, 32'(start), N));
        end
    end

endmodule

// File: rtl/prio_event_encoder.sv
// Priority event encoder: latches request pulses into a pending register and
// hands the selected index to one consumer over valid/ready. Bit 0 has the
// highest priority. Define PRIO_ENC_ROUND_ROBIN_EN to rotate the search start
// past the last accepted index (round-robin); default build is fixed priority.
module prio_event_encoder
    import prio_enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             flush_i,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N-1:0]     pend_o,
    output logic [N-1:0]     lost_o
);

    logic [N-1:0]     pend_reg;
    logic [N-1:0]     lost_reg;
    logic [N-1:0]     clr_mask;
    logic [IDX_W-1:0] start;
    logic             sel_any;
    logic [IDX_W-1:0] sel_idx;
    logic             fire;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_reg;

    // Rotate the search start to just past the accepted index; hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (fire) begin
            ptr_reg <= (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + IDX_W'(1);
        end
    end

    assign start = ptr_reg;
`else
    assign start = '0;
`endif

    prio_pick #(.N(N)) u_pick (
        .vec   (pend_reg),
        .start (start),
        .any   (sel_any),
        .idx   (sel_idx)
    );

    assign fire = sel_any & out_ready;

    // One-hot clear for the index accepted this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_clr
            assign clr_mask[gi] = fire && (sel_idx == IDX_W'(gi));
        end
    endgenerate

    // Pending/lost update: a re-request of the bit being accepted is a new
    // event, a re-request of a still-pending bit is recorded as lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_reg <= '0;
            lost_reg <= '0;
        end else if (flush_i) begin
            pend_reg <= '0;
            lost_reg <= '0;
        end else begin
            pend_reg <= (pend_reg & ~clr_mask) | req_i;
            lost_reg <= lost_reg | (req_i & pend_reg & ~clr_mask);
        end
    end

    assign out_valid = sel_any;
    assign out_idx   = sel_idx;
    assign pend_o    = pend_reg;
    assign lost_o    = lost_reg;

endmodule
